// File: rtl/command_issuer_if.sv
// Command issuer bus: producer-side valid/ready push plus the
// controller-side command word and syscall pulse.
interface command_issuer_if;
    logic        in_valid;
    logic [11:0] in_cmd;
    logic        in_ready;
    logic [11:0] command;
    logic        syscall;

    modport slave (
        input  in_valid,
        input  in_cmd,
        output in_ready,
        output command,
        output syscall
    );

    modport master (
        output in_valid,
        output in_cmd,
        input  in_ready,
        input  command,
        input  syscall
    );
endinterface

// File: rtl/command_issuer.sv
// Command issuer: FIFO-buffers 12-bit commands and paces them into a
// controller with no back-pressure, holding each command for its op latency.
// Ports: clk, rst_n (async low); bus (in_valid/in_cmd/in_ready push side,
// command/syscall controller side); flush (sync queue clear);
// busy, count (FIFO occupancy), issued_cnt (wrapping issue count).
module command_issuer #(
    parameter int DEPTH   = 8,
    parameter int OP_LAT  = 4,
    parameter int CAS_LAT = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    command_issuer_if.slave          bus,
    input  logic                     flush,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              issued_cnt
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXL = (OP_LAT > CAS_LAT) ? OP_LAT : CAS_LAT;
    localparam int WW   = $clog2(MAXL + 1);

    typedef enum logic {IDLE, WAIT} state_e;

    logic [11:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    state_e        state_q;
    logic [WW-1:0] wait_q;
    logic [11:0]   cmd_q;
    logic          sys_q;
    logic [15:0]   iss_q;

    logic          push, pop;
    logic [11:0]   head;
    logic [WW-1:0] lat;

    assign bus.in_ready = !flush && (cnt_q < CW'(DEPTH));
    assign push = bus.in_valid && bus.in_ready;
    // A flush edge never pops, so the queue really ends up empty.
    assign pop  = (state_q == IDLE) && (cnt_q != '0) && !flush;
    assign head = mem_q[rd_q];
    assign lat  = (head[11:9] == 3'b111) ? WW'(CAS_LAT) : WW'(OP_LAT);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
    end

    // Storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= bus.in_cmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push)
                wr_q <= wr_q + AW'(1);
            if (pop)
                rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            cmd_q   <= '0;
            sys_q   <= 1'b0;
            iss_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sys_q <= 1'b0;
                    if (pop) begin
                        cmd_q   <= head;
                        sys_q   <= 1'b1;
                        wait_q  <= lat;
                        iss_q   <= iss_q + 16'd1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // WAIT spans exactly lat cycles; command is frozen.
                    sys_q  <= 1'b0;
                    wait_q <= wait_q - WW'(1);
                    if (wait_q == WW'(1))
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.command = cmd_q;
    assign bus.syscall = sys_q;
    assign busy        = (state_q == WAIT);
    assign count       = cnt_q;
    assign issued_cnt  = iss_q;
endmodule

// File: tb/tb_command_issuer.sv
// Testbench for command_issuer: per-cycle vector table for issue timing,
// plus directed full/wrap, flush and async-reset sequences.
module tb_command_issuer;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          busy;
    logic [CW-1:0] count;
    logic [15:0]   issued_cnt;

    int checks = 0;
    int errors = 0;

    command_issuer_if bus ();

    command_issuer #(
        .DEPTH   (8),
        .OP_LAT  (4),
        .CAS_LAT (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush      (flush),
        .busy       (busy),
        .count      (count),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [11:0] cmd;
        logic        fl;
        logic        rdy;
        logic [3:0]  cnt;
        logic        sys;
        logic        bsy;
        logic [11:0] ocmd;
        logic [15:0] iss;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [11:0] cmd, logic fl,
                                logic rdy, logic [3:0] cnt, logic sys,
                                logic bsy, logic [11:0] ocmd,
                                logic [15:0] iss);
        vec_t r;
        r.v = v; r.cmd = cmd; r.fl = fl; r.rdy = rdy; r.cnt = cnt;
        r.sys = sys; r.bsy = bsy; r.ocmd = ocmd; r.iss = iss;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nxt;
        int exp_cmd;
        int cyc;
        bit acc;
        bit saw_full;
        logic [15:0] exp_iss;

        bus.in_valid = 1'b0;
        bus.in_cmd   = '0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.command", bus.command, 12'h000);
        chk("rst.syscall", bus.syscall, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.count", count, 4'd0);
        chk("rst.in_ready", bus.in_ready, 1'b1);
        chk("rst.issued", issued_cnt, 16'd0);

        // Single ADD 057 (L=4)
        tbl.push_back(mk(1, 12'h057, 0, 1, 0, 0, 0, 12'h000, 0));
        tbl.push_back(mk(0, 12'h000, 0, 1, 1, 0, 0, 12'h000, 0));
        tbl.push_back(mk(0, 12'h000, 0, 1, 0, 1, 1, 12'h057, 1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 12'h000, 0, 1, 0, 0, 1, 12'h057, 1));
        tbl.push_back(mk(0, 12'h000, 0, 1, 0, 0, 0, 12'h057, 1));
        // Back-to-back 057, E53 (CAS, L=5), 457: syscall at T, T+5, T+11
        tbl.push_back(mk(1, 12'h057, 0, 1, 0, 0, 0, 12'h057, 1));
        tbl.push_back(mk(1, 12'hE53, 0, 1, 1, 0, 0, 12'h057, 1));
        tbl.push_back(mk(1, 12'h457, 0, 1, 1, 1, 1, 12'h057, 2));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 12'h000, 0, 1, 2, 0, 1, 12'h057, 2));
        tbl.push_back(mk(0, 12'h000, 0, 1, 2, 0, 0, 12'h057, 2));
        tbl.push_back(mk(0, 12'h000, 0, 1, 1, 1, 1, 12'hE53, 3));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 12'h000, 0, 1, 1, 0, 1, 12'hE53, 3));
        tbl.push_back(mk(0, 12'h000, 0, 1, 1, 0, 0, 12'hE53, 3));
        tbl.push_back(mk(0, 12'h000, 0, 1, 0, 1, 1, 12'h457, 4));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 12'h000, 0, 1, 0, 0, 1, 12'h457, 4));
        tbl.push_back(mk(0, 12'h000, 0, 1, 0, 0, 0, 12'h457, 4));

        for (int i = 0; i < tbl.size(); i++) begin
            tick();
            bus.in_valid = tbl[i].v;
            bus.in_cmd   = tbl[i].cmd;
            flush        = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("vec%0d.in_ready", i), bus.in_ready, tbl[i].rdy);
            chk($sformatf("vec%0d.count", i), count, tbl[i].cnt);
            chk($sformatf("vec%0d.syscall", i), bus.syscall, tbl[i].sys);
            chk($sformatf("vec%0d.busy", i), busy, tbl[i].bsy);
            chk($sformatf("vec%0d.command", i), bus.command, tbl[i].ocmd);
            chk($sformatf("vec%0d.issued", i), issued_cnt, tbl[i].iss);
        end
        exp_iss = 16'd4;

        // Full / wrap: 20 commands 001..014 with in_valid held high
        nxt = 1;
        exp_cmd = 1;
        cyc = 0;
        acc = 1'b0;
        saw_full = 1'b0;
        while (exp_cmd <= 20 && cyc < 500) begin
            tick();
            cyc++;
            if (acc)
                nxt++;
            if (bus.syscall) begin
                chk("wrap.order", bus.command, 32'(exp_cmd));
                exp_cmd++;
            end
            chk("wrap.count_le8", count <= 4'd8, 1'b1);
            chk("wrap.in_ready", bus.in_ready, count < 4'd8);
            if (count == 4'd8)
                saw_full = 1'b1;
            bus.in_valid = (nxt <= 20);
            bus.in_cmd   = 12'(nxt);
            acc = bus.in_valid && bus.in_ready;
        end
        bus.in_valid = 1'b0;
        chk("wrap.timeout", cyc < 500, 1'b1);
        chk("wrap.all_issued", exp_cmd, 21);
        chk("wrap.saw_full", saw_full, 1'b1);
        repeat (6) tick();
        chk("wrap.busy_end", busy, 1'b0);
        chk("wrap.count_end", count, 4'd0);
        exp_iss = exp_iss + 16'd20;
        chk("wrap.issued", issued_cnt, exp_iss);

        // Flush during WAIT of first of three queued commands
        tick();
        bus.in_valid = 1'b1;
        bus.in_cmd   = 12'h111;
        tick();
        bus.in_cmd   = 12'h222;
        tick();
        bus.in_cmd   = 12'h333;
        chk("flush.sys_T", bus.syscall, 1'b1);
        chk("flush.cmd_T", bus.command, 12'h111);
        tick();
        chk("flush.count_pre", count, 4'd2);
        flush        = 1'b1;
        bus.in_cmd   = 12'h444;
        #1;
        chk("flush.in_ready", bus.in_ready, 1'b0);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush.count", count, 4'd0);
        chk("flush.busy", busy, 1'b1);
        chk("flush.cmd_hold", bus.command, 12'h111);
        tick();
        chk("flush.busy_T3", busy, 1'b1);
        chk("flush.cmd_T3", bus.command, 12'h111);
        tick();
        chk("flush.busy_T4", busy, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("flush.no_syscall", bus.syscall, 1'b0);
        end
        chk("flush.count_end", count, 4'd0);
        chk("flush.cmd_end", bus.command, 12'h111);
        exp_iss = exp_iss + 16'd1;
        chk("flush.issued", issued_cnt, exp_iss);

        // Async reset mid-WAIT
        tick();
        bus.in_valid = 1'b1;
        bus.in_cmd   = 12'h0AB;
        tick();
        bus.in_cmd   = 12'hE00;
        tick();
        bus.in_valid = 1'b0;
        chk("areset.sys_pre", bus.syscall, 1'b1);
        chk("areset.count_pre", count, 4'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.syscall", bus.syscall, 1'b0);
        chk("areset.busy", busy, 1'b0);
        chk("areset.count", count, 4'd0);
        chk("areset.command", bus.command, 12'h000);
        chk("areset.issued", issued_cnt, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("areset.no_syscall", bus.syscall, 1'b0);
        end
        chk("areset.count_end", count, 4'd0);
        chk("areset.cmd_end", bus.command, 12'h000);
        chk("areset.issued_end", issued_cnt, 16'd0);
        chk("areset.ready_end", bus.in_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
